// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment glyphs in {a,b,c,d,e,f,g} order.
package seg7_pkg;
  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;
endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD-to-segment decode; non-BCD codes render as a dash, blank forces all-off.
module bcd_seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with shadow capture, leading-zero
// suppression, a one-cycle inter-digit blank and selectable output polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      lz_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic INV = ACTIVE_LOW;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] sh_bcd;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_lz;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    run;
  logic [3:0]              cur_code;
  logic                    cur_dp, cur_lz, active, blank;
  logic [NUM_DIGITS-1:0]   an_raw;
  logic [6:0]              seg_raw;

  // lead_zero[k]: digit k and every more-significant digit are zero
  always_comb begin
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run && (sh_bcd[4*k +: 4] == 4'd0);
      lead_zero[k] = run;
    end
  end

  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    an_raw   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_code  = sh_bcd[4*k +: 4];
        cur_dp    = sh_dp[k];
        cur_lz    = lead_zero[k] && (k != 0);
        an_raw[k] = active;
      end
    end
  end

  // cnt==0 is the anti-ghosting blank at the head of each slot
  assign active = (cnt != '0);
  assign blank  = !active || (sh_lz && cur_lz);

  bcd_seg7_decode u_dec (
    .code  (cur_code),
    .blank (blank),
    .seg   (seg_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt        <= '0;
      idx        <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      frame_tick <= (idx == IDX_W'(NUM_DIGITS - 1));
    end else begin
      cnt        <= cnt + 1'b1;
      frame_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bcd <= '0;
      sh_dp  <= '0;
      sh_lz  <= 1'b0;
    end else if (load) begin
      sh_bcd <= bcd_in;
      sh_dp  <= dp_in;
      sh_lz  <= lz_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{INV}};
      dp  <= INV;
      an  <= {NUM_DIGITS{INV}};
    end else begin
      seg <= seg_raw ^ {7{INV}};
      dp  <= (active && cur_dp) ^ INV;
      an  <= an_raw ^ {NUM_DIGITS{INV}};
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: two drivers (active-high and active-low) fed the same stimulus,
// checked cycle by cycle against a scoreboard filled from an independent scan model.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   bcd_in;
  logic [3:0]    dp_in;
  logic          load, lz_en;
  logic [6:0]    seg_a, seg_b;
  logic          dp_a, dp_b, ft_a, ft_b;
  logic [3:0]    an_a, an_b;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .lz_en(lz_en), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a));

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .lz_en(lz_en), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b));

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t        sb[$];
  int          k;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic        m_lz;
  int          vecs = 0;
  int          errs = 0;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k     = 0;
    m_bcd = '0;
    m_dp  = '0;
    m_lz  = 1'b0;
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, ".seg_a"}, {1'b0, seg_a}, 8'h00);
    chk({tag, ".an_a"},  {4'h0, an_a},  8'h00);
    chk({tag, ".dp_a"},  {7'h0, dp_a},  8'h00);
    chk({tag, ".ft_a"},  {7'h0, ft_a},  8'h00);
    chk({tag, ".seg_b"}, {1'b0, seg_b}, 8'h7f);
    chk({tag, ".an_b"},  {4'h0, an_b},  8'h0f);
    chk({tag, ".dp_b"},  {7'h0, dp_b},  8'h01);
  endtask

  // One clock edge: predict outputs from pre-edge model state, then compare after the edge.
  task automatic tick(input string tag);
    exp_t e;
    int   cnt_m, slot;
    logic act, lzb;
    k++;
    cnt_m = (k - 1) % RD;
    slot  = ((k - 1) / RD) % ND;
    act   = (cnt_m != 0);
    lzb   = m_lz && (slot != 0) && ((m_bcd >> (4 * slot)) == 16'h0);
    e.tag = tag;
    e.seg = (!act || lzb) ? 7'b0 : glyph(m_bcd[4*slot +: 4]);
    e.an  = act ? 4'(1 << slot) : 4'b0;
    e.dp  = act && m_dp[slot];
    e.ft  = ((k % (ND * RD)) == 0);
    sb.push_back(e);
    if (load) begin
      m_bcd = bcd_in;
      m_dp  = dp_in;
      m_lz  = lz_en;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".seg_a"}, {1'b0, seg_a}, {1'b0, e.seg});
    chk({e.tag, ".an_a"},  {4'h0, an_a},  {4'h0, e.an});
    chk({e.tag, ".dp_a"},  {7'h0, dp_a},  {7'h0, e.dp});
    chk({e.tag, ".ft_a"},  {7'h0, ft_a},  {7'h0, e.ft});
    chk({e.tag, ".seg_b"}, {1'b0, seg_b}, {1'b0, ~e.seg});
    chk({e.tag, ".an_b"},  {4'h0, an_b},  {4'h0, ~e.an});
    chk({e.tag, ".dp_b"},  {7'h0, dp_b},  {7'h0, ~e.dp});
    chk({e.tag, ".ft_b"},  {7'h0, ft_b},  {7'h0, e.ft});
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_load(input string tag, input logic [15:0] b, input logic [3:0] d, input logic lz);
    bcd_in = b;
    dp_in  = d;
    lz_en  = lz;
    load   = 1'b1;
    tick(tag);
    load   = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    bcd_in = '0;
    dp_in  = '0;
    load   = 1'b0;
    lz_en  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_inactive("reset");

    @(negedge clk);
    rst_n = 1'b1;
    run("scan", 2 * ND * RD);

    do_load("ld9876", 16'h9876, 4'b0000, 1'b0);
    run("dec9876", ND * RD);
    do_load("ld5432", 16'h5432, 4'b0000, 1'b0);
    run("dec5432", ND * RD);
    do_load("ld0010", 16'h0010, 4'b0000, 1'b0);
    run("dec0010", ND * RD);

    do_load("ldFA00", 16'hFA00, 4'b0000, 1'b0);
    run("invalid", ND * RD);

    do_load("ldlz1", 16'h0070, 4'b0100, 1'b1);
    run("lz_on", ND * RD);
    do_load("ldlz0", 16'h0070, 4'b0000, 1'b0);
    run("lz_off", ND * RD);
    do_load("ldlz8", 16'h8000, 4'b0000, 1'b1);
    run("lz_top", ND * RD);
    do_load("ldlz0000", 16'h0000, 4'b1000, 1'b1);
    run("lz_all0", ND * RD);

    do_load("ld0001", 16'h0001, 4'b0001, 1'b0);
    run("pol_dp", ND * RD);

    // load lands mid-slot; glyph must change while the scan cadence is unaffected
    while ((k % RD) != 2) tick("align");
    do_load("ldmid", 16'h1234, 4'b1010, 1'b0);
    run("midload", ND * RD);

    // async reset mid-slot blanks outputs before any clock edge
    while ((k % RD) != 2) tick("align2");
    rst_n = 1'b0;
    #1;
    chk_inactive("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run("restart", ND * RD + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver for N BCD digits.
- Captures a packed BCD word on a load strobe and scans the digits one at a time with a programmable refresh period.
- Adds a blanking interval between digits, leading-zero suppression, decimal points, an invalid-code glyph and selectable output polarity.
- Sits between the counter/datapath logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal range 1..8).
- REFRESH_DIV, 1000, clock cycles per digit slot (must be >= 2).
- ACTIVE_LOW, 0, 1 = common-anode board: seg, dp and an are all inverted at the output registers.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_in  input  4*NUM_DIGITS  packed BCD digits; digit k occupies bcd_in[4k+3:4k]; digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- load  input  1  on a rising edge with load=1, bcd_in, dp_in and lz_en are captured into shadow registers.
- lz_en  input  1  leading-zero suppression enable.
- seg  output  7  segments {a,b,c,d,e,f,g}; seg[6]=a.
- dp  output  1  decimal-point segment.
- an  output  NUM_DIGITS  digit enables, one-hot or all-off.
- frame_tick  output  1  one-cycle pulse each time the scan wraps from the last digit to digit 0.

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, idx=0, shadow BCD=0, shadow dp=0, shadow lz=0, frame_tick=0.
  - seg, dp and an are driven to their inactive level: all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1.
  - Reset asserted mid-scan blanks the outputs immediately (asynchronous).
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt=REFRESH_DIV-1: cnt<=0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
  - frame_tick<=1 on exactly the edge where idx wraps to 0; frame_tick is 0 otherwise.
- Shadow registers:
  - Update only on edges with load=1; otherwise hold. The scan never stalls.
  - A load mid-slot changes the displayed glyph from the next edge on. No handshake; load may be held high continuously.
- Output registers: computed at each edge from the pre-edge cnt, idx and shadow values, so outputs lag scan state by one cycle.
  - an: one-hot(idx) when cnt!=0; all-off when cnt==0. This gives a one-cycle anti-ghosting blank at the start of every slot.
  - seg: decode of shadow digit[idx], using this table (bits a..g):
    - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
    - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
    - codes 10..15 = 0000001 (dash, g only)
  - Leading-zero suppression: when lz_en is set, digit k (k>0) is blanked (seg=0, dp follows dp_in) if digit k and every more-significant digit equal 0. Digit 0 is never suppressed. An invalid code counts as non-zero.
  - dp = shadow dp[idx]. It is gated off with an during the cnt==0 blank.
  - ACTIVE_LOW inversion is applied last, to seg, dp and an.
- First visible digit: digit 0 is enabled on the second edge after reset release.
- Full frame period: NUM_DIGITS*REFRESH_DIV cycles.
- NUM_DIGITS=1: idx stays 0 and frame_tick pulses every REFRESH_DIV cycles.

Decomposition:
- Package seg7_pkg holds:
  - the segment-pattern localparams SEG_0..SEG_9, SEG_DASH and SEG_OFF (7 bits, a..g order);
  - the max-digit constant (8).
- Sub-module bcd_seg7_decode: purely combinational, 4-bit code plus blank input to a 7-bit pattern, using the package constants.
- The scan driver instantiates the decoder once, on the idx-selected digit.

Test Plan:
- Reset and scan (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0): hold rst_n=0 -> seg=0, an=0000, frame_tick=0. Release -> an sequence 0000,0001x3,0000,0010x3,0000,0100x3,0000,1000x3; frame_tick pulses on the wrap to digit 0, period 16 cycles.
- Decode sweep: load bcd_in=0x9876 with dp_in=0000, then 0x5432, then 0x0010 -> seg matches the table per digit: digit0=6 shows 1011111, digit3=9 shows 1111011, and so on.
- Invalid codes: load 0xFA00 -> digits 3 and 2 show 0000001; digits 1 and 0 show 1111110.
- Leading-zero suppression: load 0x0070 with lz_en=1 -> digits 3 and 2 show seg=0000000, digit 1 shows 1110000, digit 0 shows 1111110. With lz_en=0, digits 3 and 2 show 1111110.
- Polarity and dp (ACTIVE_LOW=1): load 0x0001 with dp_in=0001 -> digit 0 slot gives an=1110, dp=0, seg=1001111. Blank cycles give an=1111, seg=1111111, dp=1.
- Mid-operation events: assert load in the middle of a slot -> seg changes on the next edge while idx/cnt are unaffected. Pulse rst_n low mid-slot -> outputs go inactive immediately, and the scan restarts at idx=0 with a blank cycle.
